// File: rtl/rv32i_types.sv
// Shared writeback types for the execute stage.
//   cdb_t        : one result on the common data bus (rob_idx, pd_s, rd_s, rd_v, valid)
//   NUM_FU_DEF   : default number of functional-unit result channels
//   NUM_CDB_DEF  : default number of CDB broadcast ports
//   cdb_grant_t  : one grant bit per functional unit at the default width
//   rr_wrap      : single-step modulo used by the round-robin scan
package rv32i_types;

  localparam int unsigned NUM_FU_DEF  = 3;
  localparam int unsigned NUM_CDB_DEF = 1;

  typedef struct packed {
    logic [4:0]  rob_idx;
    logic [5:0]  pd_s;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        valid;
  } cdb_t;

  typedef logic [NUM_FU_DEF-1:0] cdb_grant_t;

  // idx is always below 2*n at the call sites, so one subtraction suffices.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result buffer feeding the CDB arbiter.
//   clk, rst      : clock, asynchronous active-low reset
//   flush         : synchronous clear of pointers and count
//   push_i        : write push_data_i at the edge
//   push_data_i   : result to store
//   pop_i         : drop the head entry at the edge
//   head_o        : oldest stored result (undefined contents when empty)
//   count_o       : number of stored entries, 0..DEPTH
module cdb_result_fifo
  import rv32i_types::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push_i,
  input  cdb_t          push_data_i,
  input  logic          pop_i,
  output cdb_t          head_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  cdb_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/exec_cdb_arbiter.sv
// Execute-stage writeback: buffers single-cycle FU results in per-FU FIFOs and
// broadcasts up to NUM_CDB of them per cycle with round-robin arbitration.
//   clk, rst   : clock, asynchronous active-low reset
//   flush      : squash all buffered and incoming results
//   fu_result  : per-FU result pulse
//   fu_ready   : FU i may assert valid this cycle (registered count only)
//   cdb_out    : broadcast slots; k-th grant drives slot k, others all-zero
//   idle       : every FIFO empty
// Optional: define EXEC_CDB_BYPASS_EN to let a result arriving at an empty
// FIFO be granted in the same cycle (adds fu_result -> cdb_out path).
module exec_cdb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_FU     = NUM_FU_DEF,
  parameter int unsigned NUM_CDB    = NUM_CDB_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  cdb_t              fu_result [NUM_FU],
  output logic [NUM_FU-1:0] fu_ready,
  output cdb_t              cdb_out   [NUM_CDB],
  output logic              idle
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RRW = $clog2(NUM_FU);

  cdb_t              head      [NUM_FU];
  cdb_t              cand_data [NUM_FU];
  logic [CW-1:0]     count     [NUM_FU];
  logic [NUM_FU-1:0] nonempty, cand, grant, push, pop;
  logic [RRW-1:0]    rr_q, rr_d;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    cdb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push_i     (push[i]),
      .push_data_i(fu_result[i]),
      .pop_i      (pop[i]),
      .head_o     (head[i]),
      .count_o    (count[i])
    );

    assign nonempty[i] = (count[i] != '0);
    assign fu_ready[i] = (count[i] < CW'(FIFO_DEPTH));

`ifdef EXEC_CDB_BYPASS_EN
    // An empty FIFO offers the incoming result directly; a granted bypass is
    // neither written nor popped.
    assign cand[i]      = nonempty[i] | (fu_result[i].valid & ~flush);
    assign cand_data[i] = nonempty[i] ? head[i] : fu_result[i];
    assign push[i]      = fu_result[i].valid & fu_ready[i] & ~flush
                          & ~(grant[i] & ~nonempty[i]);
    assign pop[i]       = grant[i] & nonempty[i];
`else
    assign cand[i]      = nonempty[i];
    assign cand_data[i] = head[i];
    assign push[i]      = fu_result[i].valid & fu_ready[i] & ~flush;
    assign pop[i]       = grant[i];
`endif

    // Valid while not ready is a protocol error; the result is dropped.
    assert property (@(posedge clk) disable iff (!rst)
      !(fu_result[i].valid && !fu_ready[i] && !flush));
  end

  // Scan upward from rr_q; the n-th candidate found takes slot n.
  always_comb begin
    int unsigned    n;
    logic [RRW-1:0] idx;
    grant = '0;
    rr_d  = rr_q;
    n     = 0;
    idx   = '0;
    for (int unsigned s = 0; s < NUM_CDB; s++) cdb_out[s] = '0;
    if (!flush) begin
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        idx = RRW'(rr_wrap(32'(rr_q) + k, NUM_FU));
        if (cand[idx] && (n < NUM_CDB)) begin
          grant[idx] = 1'b1;
          for (int unsigned s = 0; s < NUM_CDB; s++) begin
            if (s == n) begin
              cdb_out[s]       = cand_data[idx];
              cdb_out[s].valid = 1'b1;
            end
          end
          rr_d = RRW'(rr_wrap(32'(idx) + 1, NUM_FU));
          n    = n + 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rr_q <= '0;
    else if (flush) rr_q <= '0;
    else            rr_q <= rr_d;
  end

  assign idle = ~|nonempty;

endmodule

// File: tb/tb_exec_cdb_arbiter.sv
module tb_exec_cdb_arbiter;
  import rv32i_types::*;

  localparam int NFU   = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  cdb_t           din0 [NFU];
  cdb_t           din1 [NFU];
  logic [NFU-1:0] rdy0, rdy1;
  cdb_t           cdb0 [1];
  cdb_t           cdb1 [2];
  logic           idle0, idle1;

  always #5 clk = ~clk;

  exec_cdb_arbiter #(.NUM_FU(3), .NUM_CDB(1), .FIFO_DEPTH(4)) u_cdb1 (
    .clk(clk), .rst(rst), .flush(flush), .fu_result(din0),
    .fu_ready(rdy0), .cdb_out(cdb0), .idle(idle0));

  exec_cdb_arbiter #(.NUM_FU(3), .NUM_CDB(2), .FIFO_DEPTH(4)) u_cdb2 (
    .clk(clk), .rst(rst), .flush(flush), .fu_result(din1),
    .fu_ready(rdy1), .cdb_out(cdb1), .idle(idle1));

  // Model: instance k (0 -> one CDB port, 1 -> two) keeps a queue per FU.
  cdb_t        mq [6][$];
  int unsigned mrr [2];
  int          tests = 0;
  int          fails = 0;
  logic        cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic cdb_t din(input int k, input int f);
    return (k == 0) ? din0[f] : din1[f];
  endfunction

  function automatic cdb_t act_cdb(input int k, input int s);
    return (k == 0) ? cdb0[0] : cdb1[s];
  endfunction

  // First k+1 non-empty queues found scanning upward from the pointer.
  function automatic void grants(input int k, output int gf [2], output int ng);
    ng = 0;
    gf[0] = 0;
    gf[1] = 0;
    if (flush) return;
    for (int j = 0; j < NFU; j++) begin
      int f;
      f = (int'(mrr[k]) + j) % NFU;
      if (mq[k*NFU+f].size() > 0 && ng < k + 1) begin
        gf[ng] = f;
        ng++;
      end
    end
  endfunction

  function automatic cdb_t exp_cdb(input int k, input int s);
    int   gf [2];
    int   ng;
    cdb_t e;
    grants(k, gf, ng);
    e = '0;
    if (s < ng) begin
      e = mq[k*NFU+gf[s]][0];
      e.valid = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [NFU-1:0] exp_ready(input int k);
    logic [NFU-1:0] r;
    for (int f = 0; f < NFU; f++) r[f] = (mq[k*NFU+f].size() < DEPTH);
    return r;
  endfunction

  function automatic logic exp_idle(input int k);
    int tot;
    tot = 0;
    for (int f = 0; f < NFU; f++) tot += mq[k*NFU+f].size();
    return (tot == 0);
  endfunction

  int             m_gf [2];
  int             m_ng;
  logic [NFU-1:0] m_rd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < 6; q++) mq[q].delete();
      mrr[0] = 0;
      mrr[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        grants(k, m_gf, m_ng);
        m_rd = exp_ready(k);
        if (flush) begin
          for (int f = 0; f < NFU; f++) mq[k*NFU+f].delete();
          mrr[k] = 0;
        end else begin
          for (int s = 0; s < m_ng; s++) void'(mq[k*NFU+m_gf[s]].pop_front());
          for (int f = 0; f < NFU; f++)
            if (din(k, f).valid && m_rd[f]) mq[k*NFU+f].push_back(din(k, f));
          if (m_ng > 0) mrr[k] = (m_gf[m_ng-1] + 1) % NFU;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ready[%0d]", k), (k == 0) ? rdy0 : rdy1, exp_ready(k));
        chk($sformatf("idle[%0d]", k), (k == 0) ? idle0 : idle1, exp_idle(k));
        for (int s = 0; s <= k; s++)
          chk($sformatf("cdb[%0d][%0d]", k, s), act_cdb(k, s), exp_cdb(k, s));
      end
    end
  end

  // Inputs are gated by the model's ready so the FUs honour backpressure.
  task automatic set_fu(input int f, input logic v, input logic [4:0] rob,
                        input logic [5:0] pd, input logic [31:0] val);
    cdb_t x;
    x.rob_idx = rob;
    x.pd_s    = pd;
    x.rd_s    = 5'(f + 1);
    x.rd_v    = val;
    x.valid   = v && (mq[f].size() < DEPTH);
    din0[f]   = x;
    x.valid   = v && (mq[NFU+f].size() < DEPTH);
    din1[f]   = x;
  endtask

  task automatic clear_in();
    for (int f = 0; f < NFU; f++) begin
      din0[f] = '0;
      din1[f] = '0;
    end
  endtask

  task automatic push_all(input int base);
    for (int f = 0; f < NFU; f++)
      set_fu(f, 1'b1, 5'(base + f), 6'(base + f + 1), $urandom);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    next_cycle();
    clear_in();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
  endtask

  logic [4:0] ord1 [6];
  cdb_t       lit;

  initial begin
    clear_in();
    #1;
    chk("rst_ready", rdy0, 3'b111);
    chk("rst_idle", idle0, 1'b1);
    chk("rst_cdb", cdb0[0], '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Single result from FU1.
    next_cycle();
    set_fu(1, 1'b1, 5'd5, 6'd12, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_c0_valid", cdb0[0].valid, 1'b0);
    next_cycle();
    clear_in();
    @(negedge clk);
    lit = '{rob_idx: 5'd5, pd_s: 6'd12, rd_s: 5'd2, rd_v: 32'hDEADBEEF, valid: 1'b1};
    chk("single_c1", cdb0[0], lit);
    do_flush();

    // Contention: two rounds from all three FUs.
    ord1 = '{5'd10, 5'd11, 5'd12, 5'd20, 5'd21, 5'd22};
    push_all(10);
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 1) push_all(20);
      else clear_in();
      @(negedge clk);
      chk($sformatf("order1_c%0d", c), cdb0[0].rob_idx, ord1[c-1]);
      if (c == 1) begin
        chk("two_c1_s0", cdb1[0].rob_idx, 5'd10);
        chk("two_c1_s1", cdb1[1].rob_idx, 5'd11);
      end else if (c == 2) begin
        chk("two_c2_s0", cdb1[0].rob_idx, 5'd12);
        chk("two_c2_s1", cdb1[1].rob_idx, 5'd20);
      end else if (c == 3) begin
        chk("two_c3_s0", cdb1[0].rob_idx, 5'd21);
        chk("two_c3_s1", cdb1[1].rob_idx, 5'd22);
      end else if (c == 4) begin
        chk("two_c4_idle", idle1, 1'b1);
      end
    end
    do_flush();

    // Backpressure: every FU requests for six cycles.
    for (int c = 0; c < 7; c++) begin
      if (c < 6) push_all(c * 3);
      else clear_in();
      @(negedge clk);
      if (c == 5) chk("bp_ready_c5", rdy0, 3'b001);
      if (c == 6) chk("bp_ready_c6", rdy0, 3'b010);
      next_cycle();
    end
    clear_in();
    repeat (14) next_cycle();
    @(negedge clk);
    chk("bp_drained", idle0, 1'b1);
    do_flush();

    // Flush with three buffered entries plus an incoming result.
    push_all(1);
    next_cycle();
    clear_in();
    set_fu(0, 1'b1, 5'd4, 6'd5, 32'h1234);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_v1", cdb0[0].valid, 1'b0);
    chk("flush_v2a", cdb1[0].valid, 1'b0);
    chk("flush_v2b", cdb1[1].valid, 1'b0);
    next_cycle();
    flush = 1'b0;
    clear_in();
    @(negedge clk);
    chk("flush_idle", idle0, 1'b1);
    chk("flush_ready", rdy0, 3'b111);
    chk("flush_after_v", cdb0[0].valid, 1'b0);

    // Asynchronous reset with full FIFOs.
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      push_all(c);
    end
    next_cycle();
    clear_in();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ready1", rdy0, 3'b111);
    chk("arst_ready2", rdy1, 3'b111);
    chk("arst_idle", idle0 & idle1, 1'b1);
    chk("arst_cdb1", cdb0[0], '0);
    chk("arst_cdb2", {cdb1[0], cdb1[1]}, '0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (2) begin
      next_cycle();
      @(negedge clk);
      chk("arst_post_v", cdb0[0].valid | cdb1[0].valid | cdb1[1].valid, 1'b0);
      chk("arst_post_idle", idle0, 1'b1);
    end

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
